// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 8-bit ALU between NUM_REQ
// requesters, with a one-entry registered response returned to the issuer.

package cpu_common;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SL  = 4'd5,
    ALU_SR  = 4'd6,
    ALU_MUL = 4'd7
  } alu_operation_t;

  typedef enum logic [0:0] {
    ALU_RX  = 1'b0,
    ALU_IMM = 1'b1
  } alu_operand_t;
endpackage

module alu_arbiter_sva #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input logic               clk_i,
  input logic               rst_i,
  input logic [NUM_REQ-1:0] req_valid_i,
  input logic [NUM_REQ-1:0] req_ready_i,
  input logic [NUM_REQ-1:0] rsp_valid_i,
  input logic [NUM_REQ-1:0] rsp_ready_i,
  input logic               full_i,
  input logic [IW-1:0]      owner_i
);
  a_rsp_valid_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(rsp_valid_i));

  a_req_ready_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(req_ready_i));

  a_no_overwrite: assert property (@(posedge clk_i) disable iff (rst_i)
    (full_i && (|(req_valid_i & req_ready_i))) |-> rsp_ready_i[owner_i]);
endmodule

module alu_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NUM_REQ-1:0]                       req_valid_i,
  output logic [NUM_REQ-1:0]                       req_ready_o,
  input  cpu_common::alu_operation_t [NUM_REQ-1:0] req_operation_i,
  input  logic [NUM_REQ-1:0][7:0]                  req_a_i,
  input  logic [NUM_REQ-1:0][7:0]                  req_b_i,
  output logic [NUM_REQ-1:0]                       rsp_valid_o,
  input  logic [NUM_REQ-1:0]                       rsp_ready_i,
  output logic [7:0]                               rsp_data_o,
  output cpu_common::alu_operation_t               alu_operation_o,
  output cpu_common::alu_operand_t                 alu_operand_o,
  output logic [7:0]                               alu_r0_o,
  output logic [7:0]                               alu_rx_o,
  output logic [7:0]                               alu_immediate_o,
  input  logic [7:0]                               alu_result_i
);

  localparam int            IW       = $clog2(NUM_REQ);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
  localparam logic [0:0]    EMPTY    = 1'b0;
  localparam logic [0:0]    FULL     = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [7:0]    data_q, data_d;

  logic [IW:0]   pick_s;
  logic          found_s;
  logic [IW-1:0] winner_s;
  logic          can_issue_s;
  logic          accept_s;
  logic          drain_s;

  // Returns {found, index} of the first valid requester after 'last', wrapping.
  function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                          input logic [IW-1:0]      last);
    logic [IW:0]   pick;
    logic [IW-1:0] idx;
    pick = '0;
    idx  = last;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == LAST_IDX) ? '0 : idx + IW'(1);
      if (!pick[IW] && valid[idx]) begin
        pick = {1'b1, idx};
      end
    end
    return pick;
  endfunction

  // Round-robin winner and the grant it receives when the response slot is free.
  always_comb begin
    pick_s      = rr_pick(req_valid_i, last_q);
    found_s     = pick_s[IW];
    winner_s    = pick_s[IW-1:0];
    can_issue_s = (state_q == EMPTY) || rsp_ready_i[owner_q];
    drain_s     = (state_q == FULL) && rsp_ready_i[owner_q];
    req_ready_o = '0;
    if (rst_i) begin
      req_ready_o = '0;
    end else if (found_s) begin
      req_ready_o[winner_s] = can_issue_s;
    end else begin
      req_ready_o = '0;
    end
    accept_s = |(req_valid_i & req_ready_o);
  end

  // ALU drive: winner payload, or a benign ADD of zeros when nobody requests.
  always_comb begin
    alu_operand_o   = cpu_common::ALU_RX;
    alu_immediate_o = 8'h00;
    alu_operation_o = cpu_common::ALU_ADD;
    alu_r0_o        = 8'h00;
    alu_rx_o        = 8'h00;
    if (found_s) begin
      alu_operation_o = req_operation_i[winner_s];
      alu_r0_o        = req_a_i[winner_s];
      alu_rx_o        = req_b_i[winner_s];
    end else begin
      alu_operation_o = cpu_common::ALU_ADD;
    end
  end

  // Response slot FSM: an accept refills it even while the old result drains.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    data_d  = data_q;
    case (state_q)
      EMPTY, FULL: begin
        if (accept_s) begin
          state_d = FULL;
          owner_d = winner_s;
          last_d  = winner_s;
          data_d  = alu_result_i;
        end else if (drain_s) begin
          state_d = EMPTY;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State registers with synchronous reset; priority restarts at requester 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      owner_q <= '0;
      last_q  <= LAST_IDX;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  // One-hot response valid decoded from the registered owner.
  always_comb begin
    rsp_valid_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_o[i] = (state_q == FULL) && (owner_q == IW'(i));
    end
  end

  assign rsp_data_o = data_q;

  alu_arbiter_sva #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_sva (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_i (req_ready_o),
    .rsp_valid_i (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .full_i      (state_q == FULL),
    .owner_i     (owner_q)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter (NUM_REQ=2) with a behavioural ALU attached.

module tb_alu_arbiter;

  logic                             clk = 1'b0;
  logic                             rst;
  logic [1:0]                       req_valid, req_ready, rsp_valid, rsp_ready;
  cpu_common::alu_operation_t [1:0] req_op;
  logic [1:0][7:0]                  req_a, req_b;
  logic [7:0]                       rsp_data, alu_r0, alu_rx, alu_imm, alu_result;
  cpu_common::alu_operation_t       alu_op;
  cpu_common::alu_operand_t         alu_operand;

  typedef struct {
    logic [1:0] owner;
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(2)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_operation_i (req_op),
    .req_a_i         (req_a),
    .req_b_i         (req_b),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_data_o      (rsp_data),
    .alu_operation_o (alu_op),
    .alu_operand_o   (alu_operand),
    .alu_r0_o        (alu_r0),
    .alu_rx_o        (alu_rx),
    .alu_immediate_o (alu_imm),
    .alu_result_i    (alu_result)
  );

  // Behavioural stand-in for the shared ALU
  always_comb begin
    case (alu_op)
      cpu_common::ALU_ADD: alu_result = alu_r0 + alu_rx;
      cpu_common::ALU_SUB: alu_result = alu_r0 - alu_rx;
      cpu_common::ALU_AND: alu_result = alu_r0 & alu_rx;
      cpu_common::ALU_OR:  alu_result = alu_r0 | alu_rx;
      cpu_common::ALU_XOR: alu_result = alu_r0 ^ alu_rx;
      cpu_common::ALU_SL:  alu_result = alu_r0 << alu_rx[2:0];
      cpu_common::ALU_SR:  alu_result = alu_r0 >> alu_rx[2:0];
      cpu_common::ALU_MUL: alu_result = alu_r0 * alu_rx;
      default:             alu_result = 8'h00;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] owner, input logic [7:0] data);
    exp_t e;
    e.owner = owner;
    e.data  = data;
    sb_q.push_back(e);
  endtask

  // Check handshake outputs at the falling edge, then move to just after the next rising edge
  task automatic cyc(input logic [1:0] exp_rdy, input logic [1:0] exp_vld,
                     input logic [7:0] exp_data, input bit chk_data);
    @(negedge clk);
    check_eq("req_ready", req_ready, exp_rdy);
    check_eq("rsp_valid", rsp_valid, exp_vld);
    if (chk_data) check_eq("rsp_data", rsp_data, exp_data);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_alu(input cpu_common::alu_operation_t op, input logic [7:0] r0,
                         input logic [7:0] rx);
    #1;
    check_eq("alu_operation", alu_op, op);
    check_eq("alu_r0", alu_r0, r0);
    check_eq("alu_rx", alu_rx, rx);
    check_eq("alu_operand", alu_operand, cpu_common::ALU_RX);
    check_eq("alu_immediate", alu_imm, 8'h00);
  endtask

  // Scoreboard: a response handshake pops and compares the oldest expectation
  always @(negedge clk) begin
    if (!rst) begin
      check_eq("rsp_onehot", $onehot0(rsp_valid), 32'd1);
      if ((rsp_valid & rsp_ready) != 2'b00) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected", rsp_valid, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check_eq("sb_owner", rsp_valid, mon_e.owner);
          check_eq("sb_data", rsp_data, mon_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  cpu_common::alu_operation_t t4_op[3] = '{cpu_common::ALU_MUL, cpu_common::ALU_SL, cpu_common::ALU_SR};
  logic [1:0] t4_oh[3]  = '{2'b01, 2'b10, 2'b01};
  logic [7:0] t4_a[3]   = '{8'h10, 8'h81, 8'h80};
  logic [7:0] t4_b[3]   = '{8'h10, 8'h01, 8'h07};
  logic [7:0] t4_exp[3] = '{8'h00, 8'h02, 8'h01};

  initial begin
    logic [1:0] rdy, vld;
    logic [7:0] dat;
    rst       = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_op[0] = cpu_common::ALU_ADD;
    req_op[1] = cpu_common::ALU_ADD;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset: ready forced low even with a valid request
    req_valid = 2'b01;
    req_op[0] = cpu_common::ALU_ADD; req_a[0] = 8'h05; req_b[0] = 8'h03;
    cyc(2'b00, 2'b00, 8'h00, 1'b1);

    // Single ADD 5+3
    rst = 1'b0;
    rsp_ready = 2'b11;
    push_exp(2'b01, 8'h08);
    chk_alu(cpu_common::ALU_ADD, 8'h05, 8'h03);
    cyc(2'b01, 2'b00, 8'h00, 1'b1);
    req_valid = 2'b00;
    cyc(2'b00, 2'b01, 8'h08, 1'b1);
    chk_alu(cpu_common::ALU_ADD, 8'h00, 8'h00);
    cyc(2'b00, 2'b00, 8'h08, 1'b1);

    // Alternating grants from reset, one result per cycle
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 2'b11;
    req_op[0] = cpu_common::ALU_ADD; req_a[0] = 8'h01; req_b[0] = 8'h01;
    req_op[1] = cpu_common::ALU_XOR; req_a[1] = 8'hF0; req_b[1] = 8'hFF;
    vld = 2'b00;
    dat = 8'h00;
    for (int k = 0; k < 6; k++) begin
      rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      push_exp(rdy, (k % 2 == 0) ? 8'h02 : 8'h0F);
      cyc(rdy, vld, dat, 1'b1);
      vld = rdy;
      dat = (k % 2 == 0) ? 8'h02 : 8'h0F;
    end
    req_valid = 2'b00;
    cyc(2'b00, vld, dat, 1'b1);
    cyc(2'b00, 2'b00, dat, 1'b1);

    // Backpressure: req0 SUB 0-1 held, req1 waits, then drain+issue same cycle
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    req_op[0] = cpu_common::ALU_SUB; req_a[0] = 8'h00; req_b[0] = 8'h01;
    push_exp(2'b01, 8'hFF);
    cyc(2'b01, 2'b00, 8'h0F, 1'b1);
    req_valid = 2'b10;
    req_op[1] = cpu_common::ALU_OR; req_a[1] = 8'h0C; req_b[1] = 8'h30;
    for (int k = 0; k < 3; k++) cyc(2'b00, 2'b01, 8'hFF, 1'b1);
    rsp_ready = 2'b01;
    push_exp(2'b10, 8'h3C);
    cyc(2'b10, 2'b01, 8'hFF, 1'b1);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    cyc(2'b00, 2'b10, 8'h3C, 1'b1);
    cyc(2'b00, 2'b00, 8'h3C, 1'b1);

    // Wrap and shift passthrough, returned to the issuer only
    dat = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      req_valid = t4_oh[i];
      req_op[t4_oh[i][1]] = t4_op[i];
      req_a[t4_oh[i][1]]  = t4_a[i];
      req_b[t4_oh[i][1]]  = t4_b[i];
      push_exp(t4_oh[i], t4_exp[i]);
      cyc(t4_oh[i], 2'b00, dat, 1'b1);
      req_valid = 2'b00;
      cyc(2'b00, t4_oh[i], t4_exp[i], 1'b1);
      dat = t4_exp[i];
    end

    // Reset while a req1 result is held
    req_valid = 2'b10;
    rsp_ready = 2'b00;
    req_op[1] = cpu_common::ALU_AND; req_a[1] = 8'hF0; req_b[1] = 8'h3C;
    cyc(2'b10, 2'b00, 8'h01, 1'b1);
    req_valid = 2'b00;
    cyc(2'b00, 2'b10, 8'h30, 1'b1);
    rst = 1'b1;
    req_valid = 2'b10;
    cyc(2'b00, 2'b10, 8'h30, 1'b1);
    rst = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    req_op[0] = cpu_common::ALU_ADD; req_a[0] = 8'h01; req_b[0] = 8'h01;
    req_op[1] = cpu_common::ALU_XOR; req_a[1] = 8'hF0; req_b[1] = 8'hFF;
    push_exp(2'b01, 8'h02);
    cyc(2'b01, 2'b00, 8'h00, 1'b1);
    push_exp(2'b10, 8'h0F);
    cyc(2'b10, 2'b01, 8'h02, 1'b1);
    req_valid = 2'b00;
    cyc(2'b00, 2'b10, 8'h0F, 1'b1);

    // Non-owner ready must not drain req0's result
    req_valid = 2'b01;
    rsp_ready = 2'b10;
    req_op[0] = cpu_common::ALU_ADD; req_a[0] = 8'h05; req_b[0] = 8'h03;
    push_exp(2'b01, 8'h08);
    cyc(2'b01, 2'b00, 8'h0F, 1'b1);
    req_valid = 2'b10;
    cyc(2'b00, 2'b01, 8'h08, 1'b1);
    cyc(2'b00, 2'b01, 8'h08, 1'b1);
    rsp_ready = 2'b01;
    push_exp(2'b10, 8'h0F);
    cyc(2'b10, 2'b01, 8'h08, 1'b1);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    cyc(2'b00, 2'b10, 8'h0F, 1'b1);
    cyc(2'b00, 2'b00, 8'h0F, 1'b1);

    check_eq("sb_left", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
